spi_ram_bridge_p: RTL and testbench

- Parametrised successor to the fixed 8-bit SPI-slave-plus-single-port-RAM pair: one block containing the SPI slave FSM and a DEPTH x DATA_W RAM.
- Adds configurable address and data widths, separate auto-incrementing write and read pointers, and burst transfers (back-to-back words while SS_n stays low).
- Sits at the chip boundary as the register/buffer memory reached over a 4-wire SPI link clocked by clk.

---
 rtl/spi_ram_bridge_p.sv | 198 +++++++++++++++++++
 tb/tb_spi_ram_bridge_p.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_bridge_p.sv
// SPI slave bridged to a DEPTH x DATA_W RAM, with separate auto-incrementing
// write/read pointers and gap-free burst writes and reads inside one frame.
//
// Parameters:
//   ADDR_W  address width, DEPTH = 2**ADDR_W words
//   DATA_W  RAM word width and payload bits per SPI data word
// Ports:
//   clk         system clock and SPI bit clock (rising edge)
//   rst         asynchronous active-high reset
//   SS_n        slave select, active low
//   MOSI        serial in, MSB first
//   MISO        serial out, MSB first, 0 outside RD_DATA
//   busy        high whenever the FSM is not IDLE
//   parity_err  sticky write-parity error, 0 unless SPI_RAM_PARITY_EN
// Build option:
//   SPI_RAM_PARITY_EN  adds one even-parity bit after every data word
//                      in both directions
module spi_ram_bridge_p #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic parity_err
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef SPI_RAM_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // bits per data word on the wire
  localparam int WL  = DATA_W + PB;
  localparam int RXW = (ADDR_W > WL) ? ADDR_W : WL;
  localparam int CW  = $clog2(RXW) + 1;

  localparam logic [CW-1:0] A_LAST = CW'(ADDR_W - 1);
  localparam logic [CW-1:0] W_LAST = CW'(WL - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CMD     = 3'd1;
  localparam logic [2:0] WR_ADDR = 3'd2;
  localparam logic [2:0] WR_DATA = 3'd3;
  localparam logic [2:0] RD_ADDR = 3'd4;
  localparam logic [2:0] RD_WAIT = 3'd5;
  localparam logic [2:0] RD_DATA = 3'd6;

  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic              c1;
  logic [RXW-2:0]    rx;
  logic [RXW-1:0]    rx_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_inc;
  logic [WL-1:0]     tx;
  logic [WL-1:0]     pre;
  logic [DATA_W-1:0] wword;
  logic              par_ok;
  logic              we;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic [WL-1:0] enc(input logic [DATA_W-1:0] w);
`ifdef SPI_RAM_PARITY_EN
    enc = {w, ^w};
`else
    enc = w;
`endif
  endfunction

  // A word completes on the edge that shifts in its last bit, so the
  // incoming bit is folded in combinationally and bursts need no gap.
  assign rx_nxt = {rx, MOSI};
  assign wword  = rx_nxt[WL-1:PB];
  assign rd_inc = rd_ptr + 1'b1;
  assign busy   = (state != IDLE);

`ifdef SPI_RAM_PARITY_EN
  logic perr;
  assign par_ok     = ~^rx_nxt[WL-1:0];
  assign parity_err = perr;
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  assign we = (state == WR_DATA) && !SS_n &&
              (cnt == W_LAST) && par_ok;

  always_ff @(posedge clk) begin
    if (we)
      mem[wr_ptr] <= wword;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      c1     <= 1'b0;
      rx     <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      tx     <= '0;
      pre    <= '0;
      MISO   <= 1'b0;
`ifdef SPI_RAM_PARITY_EN
      perr   <= 1'b0;
`endif
    end else begin
      MISO <= 1'b0;
      if (state != IDLE && SS_n) begin
        // frame ended: drop any partial word
        state <= IDLE;
        cnt   <= '0;
        rx    <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (!SS_n) begin
              state <= CMD;
              cnt   <= '0;
            end
          end
          CMD: begin
            if (cnt == '0) begin
              c1  <= MOSI;
              cnt <= CW'(1);
            end else begin
              cnt <= '0;
              rx  <= '0;
              unique case ({c1, MOSI})
                2'b00:   state <= WR_ADDR;
                2'b01:   state <= WR_DATA;
                2'b10:   state <= RD_ADDR;
                default: state <= RD_WAIT;
              endcase
            end
          end
          WR_ADDR, RD_ADDR: begin
            rx <= rx_nxt[RXW-2:0];
            if (cnt == A_LAST) begin
              cnt   <= '0;
              state <= CMD;
              if (state == WR_ADDR)
                wr_ptr <= rx_nxt[ADDR_W-1:0];
              else
                rd_ptr <= rx_nxt[ADDR_W-1:0];
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WR_DATA: begin
            rx <= rx_nxt[RXW-2:0];
            if (cnt == W_LAST) begin
              cnt <= '0;
              if (par_ok)
                wr_ptr <= wr_ptr + 1'b1;
`ifdef SPI_RAM_PARITY_EN
              else
                perr <= 1'b1;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RD_WAIT: begin
            // prefetch keeps the next word ready for the burst reload
            tx     <= enc(mem[rd_ptr]);
            pre    <= enc(mem[rd_inc]);
            rd_ptr <= rd_inc;
            cnt    <= '0;
            state  <= RD_DATA;
          end
          RD_DATA: begin
            MISO <= tx[WL-1];
            if (cnt == W_LAST) begin
              tx     <= pre;
              pre    <= enc(mem[rd_inc]);
              rd_ptr <= rd_inc;
              cnt    <= '0;
            end else begin
              tx  <= {tx[WL-2:0], 1'b0};
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_bridge_p.sv
// Scoreboard bench for spi_ram_bridge_p: random SPI frames driven against a
// word-level RAM/pointer model; a monitor checks every streamed read word.
module tb_spi_ram_bridge_p;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int D  = 2 ** AW;
`ifdef SPI_RAM_PARITY_EN
  localparam int WL = DW + 1;
`else
  localparam int WL = DW;
`endif
  localparam logic [63:0] MASK = (64'd1 << WL) - 64'd1;

  logic clk = 1'b0;
  logic rst;
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic busy;
  logic parity_err;

  // 0: MISO must be 0, 1: capture data bit, 2: don't care
  logic [1:0] cap;

  int n_chk = 0;
  int n_pass = 0;

  logic [DW-1:0] m_mem [D];
  int            m_wr;
  int            m_rd;
  bit            m_perr;
  logic [63:0]   exp_q [$];

  spi_ram_bridge_p #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .SS_n(SS_n),
    .MOSI(MOSI),
    .MISO(MISO),
    .busy(busy),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [63:0] enc(input logic [63:0] w);
    logic [DW-1:0] d;
    d = w[DW-1:0];
    enc = 64'(d);
`ifdef SPI_RAM_PARITY_EN
    enc = (enc << 1) | 64'(^d);
`endif
  endfunction

  // monitor: assemble MISO words and compare with the scoreboard
  logic [63:0] acc = '0;
  int nb = 0;
  always @(posedge clk) begin
    #1;
    if (rst) nb = 0;
    if (cap == 2'd1) begin
      acc = {acc[62:0], MISO};
      nb++;
      if (nb == WL) begin
        nb = 0;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL rd_extra: got %h expected none", acc & MASK);
        end else begin
          chk("rd_word", acc & MASK, exp_q.pop_front());
        end
      end
    end else if (cap == 2'd0) begin
      chk("miso_idle", 64'(MISO), 64'd0);
    end
  end

  task automatic edge_(input logic ss, input logic mosi, input logic [1:0] c);
    @(negedge clk);
    SS_n = ss;
    MOSI = mosi;
    cap  = c;
  endtask

  task automatic send(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) edge_(1'b0, v[i], 2'd0);
  endtask

  task automatic begin_frame();
    edge_(1'b0, 1'($urandom), 2'd0);
    @(posedge clk);
    #1 chk("busy_on", 64'(busy), 64'd1);
  endtask

  task automatic end_frame();
    edge_(1'b1, 1'($urandom), 2'd0);
    @(posedge clk);
    #1 chk("busy_off", 64'(busy), 64'd0);
    if ($urandom_range(0, 1) == 1) edge_(1'b1, 1'b0, 2'd0);
  endtask

  task automatic do_cmd(input int c);
    send(64'(c), 2);
  endtask

  task automatic set_waddr(input int a);
    do_cmd(0);
    send(64'(a), AW);
    m_wr = a % D;
  endtask

  task automatic set_raddr(input int a);
    do_cmd(2);
    send(64'(a), AW);
    m_rd = a % D;
  endtask

  task automatic put_word(input logic [63:0] w, input bit good);
    logic [63:0] f;
    f = enc(w);
    if (!good) f = f ^ 64'd1;
    send(f, WL);
    if (good) begin
      m_mem[m_wr] = w[DW-1:0];
      m_wr = (m_wr + 1) % D;
    end else begin
      m_perr = 1'b1;
    end
  endtask

  task automatic read_words(input int n);
    do_cmd(3);
    edge_(1'b0, 1'($urandom), 2'd0);
    for (int k = 0; k < n; k++) exp_q.push_back(enc(64'(m_mem[(m_rd + k) % D])));
    for (int b = 0; b < n * WL; b++) edge_(1'b0, 1'($urandom), 2'd1);
    m_rd = (m_rd + 1 + n) % D;
  endtask

  task automatic random_frame();
    int kind;
    begin_frame();
    if ($urandom_range(0, 1) == 1) set_raddr(int'($urandom_range(0, D - 1)));
    if ($urandom_range(0, 1) == 1) set_waddr(int'($urandom_range(0, D - 1)));
    kind = int'($urandom_range(0, 5));
    if (kind <= 1) begin
      int n;
      n = int'($urandom_range(1, 4));
      do_cmd(1);
      for (int i = 0; i < n; i++) begin
        bit good;
        good = 1'b1;
`ifdef SPI_RAM_PARITY_EN
        good = ($urandom_range(0, 7) != 0);
`endif
        put_word(64'($urandom), good);
      end
      if ($urandom_range(0, 2) == 0) send(64'($urandom), int'($urandom_range(1, WL - 1)));
    end else if (kind <= 3) begin
      read_words(int'($urandom_range(1, 4)));
    end else if (kind == 4) begin
      do_cmd(int'($urandom_range(0, 1)) * 2);
      send(64'($urandom), int'($urandom_range(1, AW - 1)));
    end
    end_frame();
  endtask

  initial begin
    rst  = 1'b1;
    SS_n = 1'b1;
    MOSI = 1'b0;
    cap  = 2'd0;
    m_wr = 0;
    m_rd = 0;
    m_perr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_miso", 64'(MISO), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_perr", 64'(parity_err), 64'd0);
    rst = 1'b0;

    // fill the whole RAM so every later read has a known value
    begin_frame();
    set_waddr(0);
    do_cmd(1);
    for (int i = 0; i < D; i++) put_word(64'($urandom), 1'b1);
    end_frame();

    // single write and read
    begin_frame(); set_waddr('h3C); do_cmd(1); put_word('hA5, 1'b1); end_frame();
    begin_frame(); set_raddr('h3C); read_words(1); end_frame();

    // burst write and read across the wrap
    begin_frame(); set_waddr(D - 2); do_cmd(1);
    put_word('h11, 1'b1); put_word('h22, 1'b1); put_word('h33, 1'b1);
    end_frame();
    begin_frame(); set_raddr(D - 2); read_words(3); end_frame();

    // abort after 5 data bits: no write, pointer kept
    begin_frame(); set_waddr('h10); do_cmd(1); send(64'h1F, 5); end_frame();
    begin_frame(); set_raddr('h10); read_words(1); end_frame();
    begin_frame(); do_cmd(1); put_word('h5A, 1'b1); end_frame();
    begin_frame(); set_raddr('h10); read_words(2); end_frame();

    // reset while MISO is driving a 1
    begin_frame(); set_waddr(5); do_cmd(1); put_word('hFF, 1'b1); end_frame();
    begin_frame(); set_raddr(5); do_cmd(3);
    edge_(1'b0, 1'b0, 2'd2);
    edge_(1'b0, 1'b0, 2'd2);
    edge_(1'b0, 1'b0, 2'd2);
    @(posedge clk);
    #2 chk("pre_rst_miso", 64'(MISO), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    SS_n = 1'b1;
    cap = 2'd0;
    #1;
    chk("mid_rst_miso", 64'(MISO), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_perr", 64'(parity_err), 64'd0);
    m_wr = 0;
    m_rd = 0;
    m_perr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    begin_frame(); read_words(1); end_frame();

`ifdef SPI_RAM_PARITY_EN
    begin_frame(); set_waddr('h40); do_cmd(1); put_word('h07, 1'b0); end_frame();
    chk("perr_set", 64'(parity_err), 64'd1);
    begin_frame(); set_raddr('h40); read_words(1); end_frame();
    begin_frame(); do_cmd(1); put_word('h07, 1'b1); end_frame();
    begin_frame(); set_raddr('h40); read_words(1); end_frame();
`endif

    for (int f = 0; f < 200; f++) random_frame();

    repeat (3) @(negedge clk);
    chk("perr_final", 64'(parity_err), 64'(m_perr));
    chk("busy_final", 64'(busy), 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
